cra_next_adr: RTL and testbench

- Microcode next-address sequencer: the stage directly downstream of the condition/skip and NICOND logic.
- Consumes the skip bit (COND_ADR_10), the NICOND[7:9] dispatch code, the DRAM dispatch fields and the CRAM J/DISP/CALL fields.
- Produces the registered CRAM address for the next microinstruction.
- Holds a microcode subroutine return stack, forces page-fail traps, and provides a diagnostic address load/read path on the EBUS.

---
 rtl/cra_next_adr.sv | 208 ++++++++++++++++++++
 tb/tb_cra_next_adr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cra_next_adr.sv
// ---------------------------------------------------------------------------
// cra_next_adr - microcode next-address sequencer
//
// Computes and registers the CRAM address of the next microinstruction from
// the CRAM J/DISP/CALL fields, the skip and NICOND results and the DRAM
// dispatch fields. It also keeps a subroutine return stack, forces page-fail
// traps, and offers a diagnostic load/read path on the EBUS.
//
// Bit numbering: the CRAM documents number address bits 0..ADR_W-1 with bit 0
// as the MSB. The vectors here are declared [ADR_W-1:0], so CRAM bit k is
// vector index ADR_W-1-k (CRAM bit 10 is index 0, bits 7:9 are [3:1]).
//
// Ports
//   clk            in   microcode clock, all state changes on rising edge
//   RESET          in   synchronous active-high master reset
//   ADVANCE        in   clock enable; 0 holds all state
//   J              in   CRAM J field
//   DISP           in   CRAM dispatch select
//   CALL           in   CRAM CALL bit (push current address)
//   COND_ADR_10    in   skip-condition result
//   NICOND         in   NICOND[7:9] dispatch code
//   NICOND_TRAP_EN in   NICOND trap qualifier
//   DRAM_J         in   instruction dispatch address
//   DRAM_A         in   operand-mode dispatch
//   PAGE_ERROR     in   page-fail trap request
//   DIAG_LOAD_ADR  in   diagnostic address load strobe
//   DIAG_READ      in   diagnostic read enable
//   DIAG_SEL       in   diagnostic read select
//   EBUS_DATA_IN   in   EBUS data bits 25:35
//   CRADR          out  current CRAM address (registered)
//   SP             out  return-stack pointer
//   STACK_ERR      out  sticky stack overflow/underflow flag
//   EBUS_DRIVING   out  EBUS output enable (= DIAG_READ)
//   EBUS_DATA_OUT  out  diagnostic read data
// ---------------------------------------------------------------------------
module cra_next_adr #(
    parameter int                ADR_W       = 11,
    parameter int                STACK_DEPTH = 16,
    parameter logic [ADR_W-1:0]  PF_ADR      = 11'o1777
) (
    input  logic                            clk,
    input  logic                            RESET,
    input  logic                            ADVANCE,
    input  logic [ADR_W-1:0]                J,
    input  logic [2:0]                      DISP,
    input  logic                            CALL,
    input  logic                            COND_ADR_10,
    input  logic [2:0]                      NICOND,
    input  logic                            NICOND_TRAP_EN,
    input  logic [ADR_W-1:0]                DRAM_J,
    input  logic [2:0]                      DRAM_A,
    input  logic                            PAGE_ERROR,
    input  logic                            DIAG_LOAD_ADR,
    input  logic                            DIAG_READ,
    input  logic [1:0]                      DIAG_SEL,
    input  logic [ADR_W-1:0]                EBUS_DATA_IN,
    output logic [ADR_W-1:0]                CRADR,
    output logic [$clog2(STACK_DEPTH)-1:0]  SP,
    output logic                            STACK_ERR,
    output logic                            EBUS_DRIVING,
    output logic [ADR_W-1:0]                EBUS_DATA_OUT
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    localparam logic [2:0] DISP_NONE   = 3'd0;
    localparam logic [2:0] DISP_RETURN = 3'd1;
    localparam logic [2:0] DISP_NICOND = 3'd2;
    localparam logic [2:0] DISP_DRAM_J = 3'd3;
    localparam logic [2:0] DISP_DRAM_A = 3'd4;

    logic [ADR_W-1:0] stack_mem [STACK_DEPTH];

    // Occupancy is tracked separately from SP so that a full stack (SP wrapped
    // back to 0) can be told apart from an empty one.
    logic [SP_W:0]    cnt;
    logic             stack_empty;
    logic             stack_full;
    logic [SP_W-1:0]  sp_dec;
    logic [ADR_W-1:0] stack_top;
    logic [ADR_W-1:0] n_adr;

    logic             adv_load;
    logic             adv_pf;
    logic             adv_norm;
    logic             is_ret;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    logic [ADR_W-1:0] cradr_nxt;
    logic [SP_W-1:0]  sp_nxt;
    logic [SP_W:0]    cnt_nxt;
    logic             err_nxt;
    logic             wr_en;
    logic [SP_W-1:0]  wr_idx;

    assign stack_empty = (cnt == '0);
    assign stack_full  = (cnt == (SP_W+1)'(STACK_DEPTH));
    assign sp_dec      = SP - 1'b1;
    assign stack_top   = stack_empty ? '0 : stack_mem[sp_dec];

    // Normal next address; the OR terms land on the low-order (CRAM
    // high-numbered) bits of J.
    always_comb begin
        n_adr = J | ADR_W'(COND_ADR_10);
        case (DISP)
            DISP_NONE:   n_adr = J | ADR_W'(COND_ADR_10);
            DISP_RETURN: n_adr = stack_top | J;
            DISP_NICOND: n_adr = J | ADR_W'({NICOND, NICOND_TRAP_EN});
            DISP_DRAM_J: n_adr = DRAM_J;
            DISP_DRAM_A: n_adr = J | ADR_W'(DRAM_A);
            default:     n_adr = J | ADR_W'(COND_ADR_10);
        endcase
    end

    assign adv_load = ADVANCE & DIAG_LOAD_ADR;
    assign adv_pf   = ADVANCE & ~DIAG_LOAD_ADR & PAGE_ERROR;
    assign adv_norm = ADVANCE & ~DIAG_LOAD_ADR & ~PAGE_ERROR;
    assign is_ret   = (DISP == DISP_RETURN);

    // A page fail is a forced call: it pushes and never pops.
    assign do_push  = adv_pf | (adv_norm & CALL & ~is_ret);
    assign do_pop   = adv_norm & ~CALL & is_ret;
    // CALL with RETURN replaces the top entry in place.
    assign do_swap  = adv_norm & CALL & is_ret;

    always_comb begin
        cradr_nxt = CRADR;
        sp_nxt    = SP;
        cnt_nxt   = cnt;
        err_nxt   = STACK_ERR;
        wr_en     = 1'b0;
        wr_idx    = SP;

        if (adv_load) begin
            cradr_nxt = EBUS_DATA_IN;
            sp_nxt    = '0;
            cnt_nxt   = '0;
        end else if (adv_pf) begin
            cradr_nxt = PF_ADR;
        end else if (adv_norm) begin
            cradr_nxt = n_adr;
        end

        if (do_push) begin
            wr_en  = 1'b1;
            wr_idx = SP;
            if (stack_full) begin
                sp_nxt  = '0;
                err_nxt = 1'b1;
            end else begin
                sp_nxt  = SP + 1'b1;
                cnt_nxt = cnt + 1'b1;
            end
        end

        if (do_swap && !stack_empty) begin
            wr_en  = 1'b1;
            wr_idx = sp_dec;
        end

        if (do_pop) begin
            if (stack_empty) begin
                err_nxt = 1'b1;
            end else begin
                sp_nxt  = sp_dec;
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            CRADR     <= '0;
            SP        <= '0;
            cnt       <= '0;
            STACK_ERR <= 1'b0;
        end else begin
            CRADR     <= cradr_nxt;
            SP        <= sp_nxt;
            cnt       <= cnt_nxt;
            STACK_ERR <= err_nxt;
        end
    end

    // Stack contents are not reset; only the pointer and count are.
    always_ff @(posedge clk) begin
        if (wr_en && !RESET) begin
            stack_mem[wr_idx] <= CRADR;
        end
    end

    assign EBUS_DRIVING = DIAG_READ;

    always_comb begin
        EBUS_DATA_OUT = '0;
        if (DIAG_READ) begin
            case (DIAG_SEL)
                2'd0:    EBUS_DATA_OUT = CRADR;
                2'd1:    EBUS_DATA_OUT = stack_top;
                2'd2:    EBUS_DATA_OUT = ADR_W'({STACK_ERR, SP});
                default: EBUS_DATA_OUT = n_adr;
            endcase
        end
    end

endmodule

// File: tb/tb_cra_next_adr.sv
module tb_cra_next_adr;

    logic        clk = 1'b0;
    logic        RESET;
    logic        ADVANCE;
    logic [10:0] J;
    logic [2:0]  DISP;
    logic        CALL;
    logic        COND_ADR_10;
    logic [2:0]  NICOND;
    logic        NICOND_TRAP_EN;
    logic [10:0] DRAM_J;
    logic [2:0]  DRAM_A;
    logic        PAGE_ERROR;
    logic        DIAG_LOAD_ADR;
    logic        DIAG_READ;
    logic [1:0]  DIAG_SEL;
    logic [10:0] EBUS_DATA_IN;
    logic [10:0] CRADR;
    logic [3:0]  SP;
    logic        STACK_ERR;
    logic        EBUS_DRIVING;
    logic [10:0] EBUS_DATA_OUT;

    int tests_run    = 0;
    int tests_failed = 0;

    cra_next_adr dut (
        .clk            (clk),
        .RESET          (RESET),
        .ADVANCE        (ADVANCE),
        .J              (J),
        .DISP           (DISP),
        .CALL           (CALL),
        .COND_ADR_10    (COND_ADR_10),
        .NICOND         (NICOND),
        .NICOND_TRAP_EN (NICOND_TRAP_EN),
        .DRAM_J         (DRAM_J),
        .DRAM_A         (DRAM_A),
        .PAGE_ERROR     (PAGE_ERROR),
        .DIAG_LOAD_ADR  (DIAG_LOAD_ADR),
        .DIAG_READ      (DIAG_READ),
        .DIAG_SEL       (DIAG_SEL),
        .EBUS_DATA_IN   (EBUS_DATA_IN),
        .CRADR          (CRADR),
        .SP             (SP),
        .STACK_ERR      (STACK_ERR),
        .EBUS_DRIVING   (EBUS_DRIVING),
        .EBUS_DATA_OUT  (EBUS_DATA_OUT)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RESET = 1'b0; ADVANCE = 1'b1; J = '0; DISP = 3'd0; CALL = 1'b0;
        COND_ADR_10 = 1'b0; NICOND = '0; NICOND_TRAP_EN = 1'b0; DRAM_J = '0;
        DRAM_A = '0; PAGE_ERROR = 1'b0; DIAG_LOAD_ADR = 1'b0; DIAG_READ = 1'b0;
        DIAG_SEL = '0; EBUS_DATA_IN = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic diag_load(input logic [10:0] a);
        idle_inputs();
        DIAG_LOAD_ADR = 1'b1; EBUS_DATA_IN = a;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        diag_load(11'o1234);
        ADVANCE = 1'b0; RESET = 1'b1;
        step();
        tests_run++;
        if (CRADR !== 11'o0000) begin tests_failed++; $display("FAIL reset_cradr got %o want 0", CRADR); end
        tests_run++;
        if (SP !== 4'd0 || STACK_ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_sp_err got sp=%0d err=%b want 0/0", SP, STACK_ERR); end
        idle_inputs();
        J = 11'o0100; COND_ADR_10 = 1'b1;
        step();
        tests_run++;
        if (CRADR !== 11'o0101) begin tests_failed++; $display("FAIL skip_or got %o want 0101", CRADR); end
    endtask

    task automatic test_call_return();
        do_reset();
        diag_load(11'o0200);
        CALL = 1'b1; J = 11'o0500;
        step();
        tests_run++;
        if (CRADR !== 11'o0500 || SP !== 4'd1) begin tests_failed++; $display("FAIL call got %o sp=%0d want 0500 sp=1", CRADR, SP); end
        idle_inputs();
        DISP = 3'd1; J = 11'o0003;
        step();
        tests_run++;
        if (CRADR !== 11'o0203 || SP !== 4'd0) begin tests_failed++; $display("FAIL return got %o sp=%0d want 0203 sp=0", CRADR, SP); end
        idle_inputs();
    endtask

    task automatic test_call_with_return();
        do_reset();
        diag_load(11'o0010);
        CALL = 1'b1; J = 11'o0300;                 // push 0010
        step();
        idle_inputs();
        CALL = 1'b1; DISP = 3'd1; J = 11'o0004;    // N = 0010|0004, replace top with 0300
        step();
        tests_run++;
        if (CRADR !== 11'o0014 || SP !== 4'd1 || STACK_ERR !== 1'b0) begin
            tests_failed++; $display("FAIL call_ret got %o sp=%0d err=%b want 0014 sp=1 err=0", CRADR, SP, STACK_ERR);
        end
        idle_inputs();
        DIAG_READ = 1'b1; DIAG_SEL = 2'd1;
        #1;
        tests_run++;
        if (EBUS_DATA_OUT !== 11'o0300) begin tests_failed++; $display("FAIL call_ret_top got %o want 0300", EBUS_DATA_OUT); end
        idle_inputs();
    endtask

    task automatic test_nicond_hold();
        do_reset();
        DISP = 3'd2; J = 11'o0400; NICOND = 3'b101; NICOND_TRAP_EN = 1'b1;
        step();
        tests_run++;
        if (CRADR !== 11'o0413) begin tests_failed++; $display("FAIL nicond got %o want 0413", CRADR); end
        ADVANCE = 1'b0;
        step();
        tests_run++;
        if (CRADR !== 11'o0413) begin tests_failed++; $display("FAIL hold got %o want 0413", CRADR); end
        DIAG_LOAD_ADR = 1'b1; EBUS_DATA_IN = 11'o0123; CALL = 1'b1;
        step();
        tests_run++;
        if (CRADR !== 11'o0413 || SP !== 4'd0) begin tests_failed++; $display("FAIL hold_diag got %o sp=%0d want 0413 sp=0", CRADR, SP); end
        idle_inputs();
        DISP = 3'd4; J = 11'o0700; DRAM_A = 3'd5;
        step();
        tests_run++;
        if (CRADR !== 11'o0705) begin tests_failed++; $display("FAIL dram_a got %o want 0705", CRADR); end
        idle_inputs();
        DISP = 3'd3; DRAM_J = 11'o1357; J = 11'o0001;
        step();
        tests_run++;
        if (CRADR !== 11'o1357) begin tests_failed++; $display("FAIL dram_j got %o want 1357", CRADR); end
        idle_inputs();
    endtask

    task automatic test_overflow();
        logic [3:0] exp_sp;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            CALL = 1'b1; J = 11'(11'o0100 + i);
            step();
            exp_sp = (i < 16) ? 4'((i + 1) % 16) : 4'd0;
            tests_run++;
            if (SP !== exp_sp || STACK_ERR !== (i == 16)) begin
                tests_failed++; $display("FAIL overflow_%0d got sp=%0d err=%b want sp=%0d err=%b", i, SP, STACK_ERR, exp_sp, (i == 16));
            end
        end
        idle_inputs();
        DIAG_READ = 1'b1; DIAG_SEL = 2'd2;
        #1;
        tests_run++;
        if (EBUS_DATA_OUT !== 11'b000000_1_0000 || EBUS_DRIVING !== 1'b1) begin
            tests_failed++; $display("FAIL diag_status got %b drv=%b want 00000010000 drv=1", EBUS_DATA_OUT, EBUS_DRIVING);
        end
        DIAG_READ = 1'b0;
        #1;
        tests_run++;
        if (EBUS_DATA_OUT !== 11'o0 || EBUS_DRIVING !== 1'b0) begin
            tests_failed++; $display("FAIL diag_off got %o drv=%b want 0 drv=0", EBUS_DATA_OUT, EBUS_DRIVING);
        end
        // Sticky: a normal cycle does not clear it.
        step();
        tests_run++;
        if (STACK_ERR !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got %b want 1", STACK_ERR); end
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            DISP = 3'd1; J = 11'o0055;
            step();
            if (i == 0) begin
                tests_run++;
                if (CRADR !== 11'o0055 || STACK_ERR !== 1'b1 || SP !== 4'd0) begin
                    tests_failed++; $display("FAIL underflow_first got %o err=%b sp=%0d want 0055 err=1 sp=0", CRADR, STACK_ERR, SP);
                end
            end
        end
        tests_run++;
        if (SP !== 4'd0 || STACK_ERR !== 1'b1) begin tests_failed++; $display("FAIL underflow_end got sp=%0d err=%b want 0/1", SP, STACK_ERR); end
        idle_inputs();
    endtask

    task automatic setup_sp2();
        do_reset();
        CALL = 1'b1; J = 11'o0010;
        step();
        J = 11'o0042;
        step();
        idle_inputs();
    endtask

    task automatic test_page_fail();
        setup_sp2();
        PAGE_ERROR = 1'b1; DISP = 3'd1; J = 11'o0003;
        step();
        tests_run++;
        if (CRADR !== 11'o1777 || SP !== 4'd3) begin tests_failed++; $display("FAIL page_fail got %o sp=%0d want 1777 sp=3", CRADR, SP); end
        idle_inputs();
        DIAG_READ = 1'b1; DIAG_SEL = 2'd1;
        #1;
        tests_run++;
        if (EBUS_DATA_OUT !== 11'o0042) begin tests_failed++; $display("FAIL page_fail_top got %o want 0042", EBUS_DATA_OUT); end
        setup_sp2();
        PAGE_ERROR = 1'b1; DISP = 3'd1; J = 11'o0003; DIAG_LOAD_ADR = 1'b1; EBUS_DATA_IN = 11'o0777;
        step();
        tests_run++;
        if (CRADR !== 11'o0777 || SP !== 4'd0) begin tests_failed++; $display("FAIL diag_over_pf got %o sp=%0d want 0777 sp=0", CRADR, SP); end
        idle_inputs();
    endtask

    // Randomized run against a queue-based return-stack model. Pushes are
    // limited so the stack never overflows; underflow is allowed.
    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] m_cradr;
        logic        m_err;
        logic [10:0] top;
        logic [10:0] n;
        logic [10:0] dout;
        int          errs;
        do_reset();
        q = {};
        m_cradr = '0;
        m_err = 1'b0;
        errs = 0;
        for (int it = 0; it < 400; it++) begin
            ADVANCE        = ($urandom_range(0, 7) != 0);
            J              = 11'($urandom);
            DISP           = 3'($urandom);
            CALL           = ($urandom_range(0, 3) == 0);
            COND_ADR_10    = 1'($urandom);
            NICOND         = 3'($urandom);
            NICOND_TRAP_EN = 1'($urandom);
            DRAM_J         = 11'($urandom);
            DRAM_A         = 3'($urandom);
            PAGE_ERROR     = ($urandom_range(0, 15) == 0);
            DIAG_LOAD_ADR  = ($urandom_range(0, 31) == 0);
            EBUS_DATA_IN   = 11'($urandom);
            DIAG_READ      = 1'($urandom);
            DIAG_SEL       = 2'($urandom);
            if (q.size() >= 15) begin
                CALL = 1'b0; PAGE_ERROR = 1'b0;
            end

            top = (q.size() > 0) ? q[q.size()-1] : 11'o0;
            if (DISP == 3'd1)      n = top | J;
            else if (DISP == 3'd2) n = J | (11'(NICOND) << 1) | 11'(NICOND_TRAP_EN);
            else if (DISP == 3'd3) n = DRAM_J;
            else if (DISP == 3'd4) n = J | 11'(DRAM_A);
            else                   n = J | 11'(COND_ADR_10);

            if (!DIAG_READ)          dout = '0;
            else if (DIAG_SEL == 0)  dout = m_cradr;
            else if (DIAG_SEL == 1)  dout = top;
            else if (DIAG_SEL == 2)  dout = 11'(m_err) * 11'd16 + 11'(q.size());
            else                     dout = n;
            #1;
            tests_run++;
            if (EBUS_DATA_OUT !== dout || EBUS_DRIVING !== DIAG_READ) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_diag it=%0d got %o want %o", it, EBUS_DATA_OUT, dout);
            end

            if (ADVANCE) begin
                if (DIAG_LOAD_ADR) begin
                    m_cradr = EBUS_DATA_IN;
                    q = {};
                end else if (PAGE_ERROR) begin
                    q.push_back(m_cradr);
                    m_cradr = 11'o1777;
                end else begin
                    if (CALL && DISP == 3'd1) begin
                        if (q.size() > 0) q[q.size()-1] = m_cradr;
                    end else if (CALL) begin
                        q.push_back(m_cradr);
                    end else if (DISP == 3'd1) begin
                        if (q.size() > 0) void'(q.pop_back());
                        else m_err = 1'b1;
                    end
                    m_cradr = n;
                end
            end

            step();
            tests_run++;
            if (CRADR !== m_cradr || SP !== 4'(q.size()) || STACK_ERR !== m_err) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_state it=%0d got %o sp=%0d err=%b want %o sp=%0d err=%b",
                                        it, CRADR, SP, STACK_ERR, m_cradr, q.size(), m_err);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b1;
        step();
        step();
        test_reset();
        test_call_return();
        test_call_with_return();
        test_nicond_hold();
        test_overflow();
        test_underflow();
        test_page_fail();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
